// File: rtl/rf_ctrl_pkg.sv
// Shared types and defaults for the register-file write scheduler.
// Holds the controller state encoding and the default port geometry.
package rf_ctrl_pkg;

  localparam int DEF_WIDTH  = 32;
  localparam int DEF_ADDR_W = 5;
  localparam int NUM_REGS   = 2 ** DEF_ADDR_W;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_CLEAR = 2'd2
  } rf_state_e;

endpackage

// File: rtl/rf_wr_slot.sv
// One-entry holding slot for a register-file write port.
// Tracks occupancy and whether the entry arrived at the most recent edge.
module rf_wr_slot #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              grant,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic [WIDTH-1:0]  in_data,
  output logic              full,
  output logic              is_new,
  output logic [ADDR_W-1:0] addr,
  output logic [WIDTH-1:0]  data
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full   <= 1'b0;
      is_new <= 1'b0;
      addr   <= '0;
      data   <= '0;
    end else begin
      full   <= load | (full & ~grant);
      is_new <= load;
      if (load) begin
        addr <= in_addr;
        data <= in_data;
      end
    end
  end

endmodule

// File: rtl/rf_write_scheduler.sv
// Merges two writeback ports onto one register-file write port and
// implements a bulk clear of registers 1..NUM_REGS-1.
module rf_write_scheduler
  import rf_ctrl_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [WIDTH-1:0]  a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [WIDTH-1:0]  b_data,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              clr_done,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [WIDTH-1:0]  rf_wdata
);

  localparam int LAST_REG = (2 ** ADDR_W) - 1;

  rf_state_e         state;
  logic [ADDR_W-1:0] clr_cnt;
  logic              rr_b;
  logic              a_full, a_new, b_full, b_new;
  logic [ADDR_W-1:0] a_slot_addr, b_slot_addr;
  logic [WIDTH-1:0]  a_slot_data, b_slot_data;
  logic              grant_a, grant_b, a_load, b_load, idle;

  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    if (a_full && b_full) begin
      // An entry that has already waited beats a freshly loaded one.
      if (a_new && !b_new)      grant_b = 1'b1;
      else if (b_new && !a_new) grant_a = 1'b1;
      else if (rr_b)            grant_b = 1'b1;
      else                      grant_a = 1'b1;
    end else begin
      grant_a = a_full;
      grant_b = b_full;
    end
  end

  assign idle     = (state == ST_IDLE);
  assign clr_busy = ~idle;
  assign a_ready  = idle & (~a_full | grant_a);
  assign b_ready  = idle & (~b_full | grant_b);
  // Writes to register 0 complete the handshake but are dropped.
  assign a_load   = a_valid & a_ready & (a_addr != '0);
  assign b_load   = b_valid & b_ready & (b_addr != '0);

  rf_wr_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_slot_a (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (a_load),
    .grant  (grant_a),
    .in_addr(a_addr),
    .in_data(a_data),
    .full   (a_full),
    .is_new (a_new),
    .addr   (a_slot_addr),
    .data   (a_slot_data)
  );

  rf_wr_slot #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) u_slot_b (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (b_load),
    .grant  (grant_b),
    .in_addr(b_addr),
    .in_data(b_data),
    .full   (b_full),
    .is_new (b_new),
    .addr   (b_slot_addr),
    .data   (b_slot_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      clr_cnt  <= '0;
      rr_b     <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      clr_done <= 1'b0;
    end else begin
      clr_done <= 1'b0;
      rf_we    <= 1'b0;

      if (grant_a)      rr_b <= 1'b1;
      else if (grant_b) rr_b <= 1'b0;

      if (state == ST_CLEAR) begin
        rf_we    <= 1'b1;
        rf_waddr <= clr_cnt;
        rf_wdata <= '0;
      end else if (grant_a) begin
        rf_we    <= 1'b1;
        rf_waddr <= a_slot_addr;
        rf_wdata <= a_slot_data;
      end else if (grant_b) begin
        rf_we    <= 1'b1;
        rf_waddr <= b_slot_addr;
        rf_wdata <= b_slot_data;
      end

      case (state)
        ST_IDLE: begin
          if (clr_req) state <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (!a_full && !b_full) begin
            state   <= ST_CLEAR;
            clr_cnt <= ADDR_W'(1);
          end
        end
        ST_CLEAR: begin
          if (clr_cnt == ADDR_W'(LAST_REG)) begin
            state    <= ST_IDLE;
            clr_cnt  <= '0;
            clr_done <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + ADDR_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rf_write_scheduler.sv
// Directed bench for rf_write_scheduler: a cycle table for single writes,
// plus hand sequences for arbitration, clear and reset-abort behaviour.
module tb_rf_write_scheduler;

  localparam int WIDTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk, rst_n;
  logic              a_valid, a_ready, b_valid, b_ready;
  logic [ADDR_W-1:0] a_addr, b_addr, rf_waddr;
  logic [WIDTH-1:0]  a_data, b_data, rf_wdata;
  logic              clr_req, clr_busy, clr_done, rf_we;

  int total = 0;
  int bad   = 0;

  rf_write_scheduler #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_addr  (a_addr),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_addr  (b_addr),
    .b_data  (b_data),
    .clr_req (clr_req),
    .clr_busy(clr_busy),
    .clr_done(clr_done),
    .rf_we   (rf_we),
    .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic              av;
    logic [ADDR_W-1:0] aa;
    logic [WIDTH-1:0]  ad;
    logic              bv;
    logic [ADDR_W-1:0] ba;
    logic [WIDTH-1:0]  bd;
    logic              ea, eb, ewe;
    logic [ADDR_W-1:0] ewa;
    logic [WIDTH-1:0]  ewd;
  } vec_t;

  typedef logic [ADDR_W+WIDTH-1:0] wr_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_valid = 1'b0; a_addr = '0; a_data = '0;
    b_valid = 1'b0; b_addr = '0; b_data = '0;
    clr_req = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    check("reset_outputs", {rf_we, rf_waddr, rf_wdata, clr_busy, clr_done}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("ready_after_reset", {a_ready, b_ready}, 2'b11);
  endtask

  function automatic vec_t mk(logic av, logic [ADDR_W-1:0] aa, logic [WIDTH-1:0] ad,
                              logic bv, logic [ADDR_W-1:0] ba, logic [WIDTH-1:0] bd,
                              logic ea, logic eb, logic ewe,
                              logic [ADDR_W-1:0] ewa, logic [WIDTH-1:0] ewd);
    vec_t v;
    v.av = av; v.aa = aa; v.ad = ad; v.bv = bv; v.ba = ba; v.bd = bd;
    v.ea = ea; v.eb = eb; v.ewe = ewe; v.ewa = ewa; v.ewd = ewd;
    return v;
  endfunction

  vec_t vt[11];
  wr_t  wq[$];

  initial begin
    // Each row: inputs this cycle, ready expected this cycle, write port seen this cycle.
    vt[0]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 0, 0);
    vt[1]  = mk(1, 5, 32'h11,       1, 6, 32'h22, 1, 1, 0, 0, 0);
    vt[2]  = mk(0, 0, 0,            0, 0, 0,     1, 0, 0, 0, 0);
    vt[3]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 5, 32'h11);
    vt[4]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 6, 32'h22);
    vt[5]  = mk(1, 3, 32'hDEADBEEF, 0, 0, 0,     1, 1, 0, 0, 0);
    vt[6]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 0, 0);
    vt[7]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 1, 3, 32'hDEADBEEF);
    vt[8]  = mk(1, 0, 32'h55,       0, 0, 0,     1, 1, 0, 0, 0);
    vt[9]  = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 0, 0);
    vt[10] = mk(0, 0, 0,            0, 0, 0,     1, 1, 0, 0, 0);

    do_reset();

    for (int i = 0; i < 11; i++) begin
      a_valid = vt[i].av; a_addr = vt[i].aa; a_data = vt[i].ad;
      b_valid = vt[i].bv; b_addr = vt[i].ba; b_data = vt[i].bd;
      #1;
      check($sformatf("row%0d_ready", i), {a_ready, b_ready}, {vt[i].ea, vt[i].eb});
      check($sformatf("row%0d_we", i), rf_we, vt[i].ewe);
      if (vt[i].ewe)
        check($sformatf("row%0d_wr", i), {rf_waddr, rf_wdata}, {vt[i].ewa, vt[i].ewd});
      tick();
    end
    idle_inputs();

    // Both ports streaming: grants must alternate A, B, A, B ...
    begin
      int ai, bi;
      logic fa, fb;
      do_reset();
      ai = 0; bi = 0;
      wq.delete();
      for (int cyc = 0; cyc < 60 && wq.size() < 16; cyc++) begin
        a_valid = (ai < 8); a_addr = 5'd8; a_data = 32'hA000 + 32'(ai);
        b_valid = (bi < 8); b_addr = 5'd9; b_data = 32'hB000 + 32'(bi);
        #1;
        fa = a_valid & a_ready;
        fb = b_valid & b_ready;
        tick();
        if (fa) ai++;
        if (fb) bi++;
        if (rf_we) wq.push_back({rf_waddr, rf_wdata});
      end
      idle_inputs();
      check("rr_write_count", 64'(wq.size()), 64'd16);
      for (int j = 0; j < wq.size(); j++) begin
        wr_t exp;
        if (j % 2 == 0) exp = {5'd8, 32'hA000 + 32'(j / 2)};
        else            exp = {5'd9, 32'hB000 + 32'(j / 2)};
        check($sformatf("rr_write%0d", j), wq[j], exp);
      end
    end

    // Clear with slot B occupied; port A waits through the clear.
    begin
      int ready_bad;
      logic done_seen;
      logic [ADDR_W-1:0] done_addr;
      do_reset();
      b_valid = 1'b1; b_addr = 5'd7; b_data = 32'h99;
      #1;
      check("clr_b_ready", b_ready, 1'b1);
      tick();
      b_valid = 1'b0;
      clr_req = 1'b1;
      #1;
      check("clr_req_cycle_ready", a_ready, 1'b1);
      tick();
      clr_req = 1'b0;
      a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h77;
      ready_bad = 0; done_seen = 1'b0; done_addr = '0;
      wq.delete();
      for (int cyc = 0; cyc < 60; cyc++) begin
        if (rf_we) wq.push_back({rf_waddr, rf_wdata});
        if (clr_busy && (a_ready || b_ready)) ready_bad++;
        if (clr_done) begin
          done_seen = 1'b1;
          done_addr = rf_waddr;
        end
        clr_req = (cyc == 15);
        if (done_seen) break;
        tick();
      end
      clr_req = 1'b0;
      check("clr_done_seen", done_seen, 1'b1);
      check("clr_done_addr", done_addr, 5'd31);
      check("clr_ready_low", 64'(ready_bad), 64'd0);
      check("clr_write_count", 64'(wq.size()), 64'd32);
      if (wq.size() == 32) begin
        check("clr_drain_write", wq[0], {5'd7, 32'h99});
        for (int j = 1; j < 32; j++)
          check($sformatf("clr_zero%0d", j), wq[j], {5'(j), 32'h0});
      end
      tick();
      a_valid = 1'b0;
      check("clr_busy_after_done", clr_busy, 1'b0);
      wq.delete();
      for (int cyc = 0; cyc < 5; cyc++) begin
        if (rf_we) wq.push_back({rf_waddr, rf_wdata});
        tick();
      end
      check("post_clr_write_count", 64'(wq.size()), 64'd1);
      if (wq.size() == 1) check("post_clr_write", wq[0], {5'd4, 32'h77});
    end

    // Reset in the middle of a clear aborts it.
    begin
      logic hit;
      int extra;
      do_reset();
      clr_req = 1'b1;
      tick();
      clr_req = 1'b0;
      hit = 1'b0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        if (rf_we && rf_waddr == 5'd10) begin
          hit = 1'b1;
          break;
        end
        tick();
      end
      check("abort_reached_addr10", hit, 1'b1);
      rst_n = 1'b0;
      #1;
      check("abort_outputs", {rf_we, clr_busy, clr_done, rf_waddr, rf_wdata}, '0);
      tick();
      rst_n = 1'b1;
      #1;
      check("abort_ready", {a_ready, b_ready}, 2'b11);
      extra = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
        tick();
        if (rf_we || clr_done || clr_busy) extra++;
      end
      check("abort_quiet", 64'(extra), 64'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_write_scheduler.md
RF_WRITE_SCHEDULER -- requirements
Module: rf_write_scheduler

Interface
REQ-001 Param WIDTH, default 32: data width of every write port.
REQ-002 Param ADDR_W, default 5: register address width; NUM_REGS = 2**ADDR_W.
REQ-003 The block SHALL use clk (input, 1): the single clock; all state changes on its rising edge.
REQ-004 The block SHALL use rst_n (input, 1): asynchronous, active-low reset.
REQ-005 The block SHALL use a_valid/a_ready (in/out, 1 each): port A (ALU writeback) handshake.
REQ-006 The block SHALL use a_addr (in, ADDR_W) and a_data (in, WIDTH): port A destination and data.
REQ-007 The block SHALL use b_valid/b_ready, b_addr and b_data (same directions and widths as port A): port B (load/external writeback).
REQ-008 The block SHALL use clr_req (in, 1): single-cycle request to zero registers 1..NUM_REGS-1.
REQ-009 The block SHALL use clr_busy (out, 1), high while a clear is pending or running; clr_done (out, 1): one-cycle pulse when a clear completes.
REQ-010 The block SHALL use rf_we (out, 1), rf_waddr (out, ADDR_W) and rf_wdata (out, WIDTH): the single register-file write port, all registered.

Function
REQ-011 Each port SHALL have a one-entry slot; x_ready = state IDLE AND (slot empty OR slot granted this cycle).
REQ-012 A transfer with x_valid & x_ready and x_addr == 0 SHALL be accepted and discarded, never loading the slot.
REQ-013 A transfer with x_valid & x_ready and x_addr != 0 SHALL load the slot at that edge and mark it "new".
REQ-014 In a cycle with one full slot, that slot SHALL be granted.
REQ-015 With both slots full, a slot that has waited at least one cycle SHALL win over a "new" one; otherwise round-robin SHALL apply, with the port not granted last winning, and A winning after reset.
REQ-016 A grant SHALL drive rf_we=1, rf_waddr and rf_wdata from the slot at the next edge, so rf_we is high in the cycle after acceptance at the earliest (1-cycle latency).
REQ-017 The block SHALL issue at most one write per cycle; rf_we SHALL be 0 in any cycle following a non-granting cycle.
REQ-018 The FSM SHALL have the states IDLE, DRAIN and CLEAR.
REQ-019 IDLE SHALL go to DRAIN on clr_req; clr_req SHALL be ignored in DRAIN and CLEAR.
REQ-020 In DRAIN, x_ready SHALL be 0 and occupied slots SHALL keep being granted; the FSM SHALL enter CLEAR when both slots are empty.
REQ-021 In CLEAR, a counter SHALL issue rf_we=1, rf_wdata=0 and rf_waddr=1,2,...,NUM_REGS-1, one per cycle.
REQ-022 After address NUM_REGS-1 the FSM SHALL return to IDLE, and clr_done SHALL pulse in the cycle rf_waddr=NUM_REGS-1 is driven.
REQ-023 clr_busy SHALL equal (state != IDLE).
REQ-024 A clear SHALL take (drain cycles + NUM_REGS-1) cycles; the counter SHALL NOT wrap past NUM_REGS-1.
REQ-025 If clr_req arrives in the same cycle as a handshake, the handshake SHALL complete (ready was 1) and that entry SHALL be drained before CLEAR.

Reset
REQ-026 On rst_n=0 the block SHALL immediately set state=IDLE, empty both slots, set the RR pointer to favour A, and zero the counter.
REQ-027 During reset, rf_we, rf_waddr, rf_wdata, clr_busy and clr_done SHALL be 0.
REQ-028 Reset asserted mid-DRAIN or mid-CLEAR SHALL abort it with no further rf_we and no clr_done.
REQ-029 x_ready SHALL be 1 in the first cycle after reset release.

Structure
REQ-030 Package rf_ctrl_pkg SHALL hold the FSM state enum, default WIDTH/ADDR_W and the NUM_REGS constant.
REQ-031 The per-port slot (valid, new flag, addr, data, load/grant) SHALL be one sub-module, rf_wr_slot, instantiated twice.

Verification
REQ-032 A: addr=3, data=0xDEADBEEF at edge k -> rf_we=1, rf_waddr=3, rf_wdata=0xDEADBEEF in cycle k+1, rf_we=0 in k+2.
REQ-033 A(5,0x11) and B(6,0x22) accepted in the same cycle, first after reset -> writes 5/0x11 then 6/0x22 on consecutive cycles.
REQ-034 Both ports valid continuously, 8 transfers each -> grants alternate A,B,A,B...; neither port is granted twice in a row while the other is full.
REQ-035 A addr=0, data=0x55 -> a_ready=1, no rf_we ever results.
REQ-036 clr_req with slot B full (7,0x99) -> 7/0x99 written first; then addrs 1..31 with data 0; clr_done with addr 31; ready=0 throughout.
REQ-037 rst_n pulsed low during CLEAR at addr 10 -> rf_we=0 immediately, clr_busy=0, no clr_done, ready=1 after release.
